// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg
//   Shared types and helpers for the shiftreg_param serialiser.
//   - state_t : FSM state encoding (IDLE, SHIFT)
//   - cnt_w() : width of a counter that must hold the values 0..width
package shiftreg_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits needed to represent 0..width inclusive (the counter must reach width).
  function automatic int cnt_w(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shiftreg_param_bitcnt.sv
// shiftreg_bitcnt
//   Bit counter for the shiftreg_param serialiser. Counts shifted bits
//   from 0 up to WIDTH.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset (count -> 0)
//   clr  in   synchronous clear (wins over inc)
//   inc  in   advance the count by one
//   hit  out  count == WIDTH (word complete)
//   last out  count == WIDTH-1 (the next increment completes the word)
module shiftreg_bitcnt
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit,
  output logic last
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign hit  = (cnt == CNT_FULL);
  assign last = (cnt == CNT_LAST);

endmodule

// File: rtl/shiftreg_param.sv
// shiftreg_param
//   Parallel-in / serial-out shift register with a parallel-load handshake,
//   per-cycle shift enable (unbounded stalls) and a one-cycle completion
//   pulse. The vacated end is filled from 'serial', so the register also
//   works as a serial-in deserialiser.
//
//   Optional build macro SHIFTREG_CAPTURE_EN adds the pdata / pdata_valid
//   outputs, which capture the received word on completion.
//
// Parameters:
//   WIDTH     register length in bits (1..64)
//   LSB_FIRST 0: shift out MSB first, 1: shift out LSB first
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   load_valid   in   parallel word offered
//   load_ready   out  load accepted this cycle (high in IDLE)
//   datain       in   WIDTH-bit parallel word
//   shift_en     in   advance one bit this cycle (SHIFT only)
//   serial       in   bit inserted at the vacated end
//   sout         out  current output-end bit (combinational)
//   busy         out  word in flight
//   done         out  one-cycle pulse after the last shift
//   pdata        out  (SHIFTREG_CAPTURE_EN) word received on completion
//   pdata_valid  out  (SHIFTREG_CAPTURE_EN) pulses with done
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a load; register holds, shift_en ignored
// SHIFT | word in flight; shifts on shift_en, loads ignored
module shiftreg_param
  import shiftreg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] datain,
  input  logic             shift_en,
  input  logic             serial,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef SHIFTREG_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] pdata,
  output logic             pdata_valid
`endif
);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_hit;
  logic             cnt_last;
  logic             load_go;
  logic             shift_go;
  logic             finish;

  // Register value after one shift toward the output end. A one-bit
  // register has no bits to move, so it simply takes the serial bit.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign shifted = serial;
    end else if (LSB_FIRST != 0) begin : g_shift_lsb
      assign shifted = {serial, sreg[WIDTH-1:1]};
    end else begin : g_shift_msb
      assign shifted = {sreg[WIDTH-2:0], serial};
    end
  endgenerate

  assign load_ready = (state == IDLE);
  assign busy       = (state == SHIFT);
  assign load_go    = load_ready & load_valid;
  assign shift_go   = busy & shift_en;
  // Completing edge: the shift that takes the count from WIDTH-1 to WIDTH.
  assign finish     = shift_go & cnt_last;

  // The counter is cleared whenever the FSM is idle. It therefore holds
  // WIDTH for exactly the one IDLE cycle after completion, which is what
  // makes 'hit' a single-cycle done pulse, and it is zero at every load.
  assign cnt_clr = (state == IDLE);
  assign cnt_inc = shift_go;

  shiftreg_bitcnt #(
    .WIDTH(WIDTH)
  ) u_bitcnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .hit (cnt_hit),
    .last(cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_go) begin
            sreg  <= datain;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_go) begin
            sreg <= shifted;
            if (finish) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign sout = (LSB_FIRST != 0) ? sreg[0] : sreg[WIDTH-1];
  assign done = cnt_hit;

`ifdef SHIFTREG_CAPTURE_EN
  // Captures the post-shift register on the completing edge, so the
  // first bit received sits at the output end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdata <= '0;
    end else if (finish) begin
      pdata <= shifted;
    end
  end

  assign pdata_valid = cnt_hit;
`endif

endmodule

// File: tb/tb_shiftreg_param.sv
module tb_shiftreg_param;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] datain;
  logic       shift_en;
  logic       serial;
  logic       load_ready0, sout0, busy0, done0;
  logic       load_ready1, sout1, busy1, done1;

  logic       lv2, se2, ser2;
  logic [0:0] d2;
  logic       lr2, so2, busy2, done2;

`ifdef SHIFTREG_CAPTURE_EN
  logic [7:0] pdata0, pdata1;
  logic [0:0] pdata2;
  logic       pv0, pv1, pv2;
`endif

  int errors = 0;
  int checks = 0;

  shiftreg_param #(.WIDTH(8), .LSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready0),
    .datain(datain), .shift_en(shift_en), .serial(serial), .sout(sout0),
    .busy(busy0), .done(done0)
`ifdef SHIFTREG_CAPTURE_EN
    , .pdata(pdata0), .pdata_valid(pv0)
`endif
  );

  shiftreg_param #(.WIDTH(8), .LSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready1),
    .datain(datain), .shift_en(shift_en), .serial(serial), .sout(sout1),
    .busy(busy1), .done(done1)
`ifdef SHIFTREG_CAPTURE_EN
    , .pdata(pdata1), .pdata_valid(pv1)
`endif
  );

  shiftreg_param #(.WIDTH(1), .LSB_FIRST(0)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(lr2),
    .datain(d2), .shift_en(se2), .serial(ser2), .sout(so2),
    .busy(busy2), .done(done2)
`ifdef SHIFTREG_CAPTURE_EN
    , .pdata(pdata2), .pdata_valid(pv2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (sout0 !== 1'b0 || sout1 !== 1'b0) begin errors++; $display("FAIL reset_sout got %b/%b need 0/0", sout0, sout1); end
    checks++; if (done0 !== 1'b0 || done1 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL reset_done got %b/%b/%b need 0", done0, done1, done2); end
    checks++; if (load_ready0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL reset_state got ready=%b busy=%b need 1/0", load_ready0, busy0); end
`ifdef SHIFTREG_CAPTURE_EN
    checks++; if (pdata0 !== 8'h00 || pv0 !== 1'b0) begin errors++; $display("FAIL reset_pdata got %h/%b need 00/0", pdata0, pv0); end
`endif
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  // Scenarios 1 and 2: A5 shifted MSB-first (dut0) and LSB-first (dut1).
  task automatic test_shift_order();
    logic [7:0] w;
    w = 8'hA5;
    datain = w; load_valid = 1'b1; shift_en = 1'b1; serial = 1'b0;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (sout0 !== w[7-i]) begin errors++; $display("FAIL msb_sout[%0d] got %b need %b", i, sout0, w[7-i]); end
      checks++; if (sout1 !== w[i]) begin errors++; $display("FAIL lsb_sout[%0d] got %b need %b", i, sout1, w[i]); end
      checks++; if (busy0 !== 1'b1 || done0 !== 1'b0 || load_ready0 !== 1'b0) begin errors++; $display("FAIL order_inflight[%0d] got busy=%b done=%b ready=%b need 1/0/0", i, busy0, done0, load_ready0); end
      serial = i[0];
      step();
    end
    checks++; if (done0 !== 1'b1 || done1 !== 1'b1) begin errors++; $display("FAIL order_done got %b/%b need 1/1", done0, done1); end
    checks++; if (busy0 !== 1'b0 || load_ready0 !== 1'b1) begin errors++; $display("FAIL order_idle got busy=%b ready=%b need 0/1", busy0, load_ready0); end
    step();
    checks++; if (done0 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL order_done_width got %b/%b need 0/0", done0, done1); end
  endtask

  // Registers now hold 55 (dut0) and AA (dut1); shift_en in IDLE must not move them.
  task automatic test_idle_hold();
    shift_en = 1'b1; serial = 1'b1; load_valid = 1'b0;
    repeat (3) step();
    checks++; if (sout0 !== 1'b0 || sout1 !== 1'b0) begin errors++; $display("FAIL idle_hold_sout got %b/%b need 0/0", sout0, sout1); end
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL idle_hold_state got busy=%b done=%b need 0/0", busy0, done0); end
  endtask

  // Scenario 3: FF with shift_en pattern 1,0,0,1,0,0,...
  task automatic test_stall();
    int  en_cnt;
    bit  finished;
    datain = 8'hFF; load_valid = 1'b1; shift_en = 1'b0; serial = 1'b0;
    step();
    load_valid = 1'b0;
    en_cnt = 0; finished = 1'b0;
    for (int k = 0; k < 40 && !finished; k++) begin
      shift_en = (k % 3 == 0);
      step();
      if (shift_en) en_cnt++;
      if (en_cnt == 8) begin
        finished = 1'b1;
        checks++; if (done0 !== 1'b1 || busy0 !== 1'b0 || done1 !== 1'b1) begin errors++; $display("FAIL stall_done edge %0d got done=%b/%b busy=%b need 1/1/0", k, done0, done1, busy0); end
      end else begin
        checks++; if (done0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL stall_hold edge %0d en=%0d got done=%b busy=%b need 0/1", k, en_cnt, done0, busy0); end
      end
    end
    if (!finished) begin
      errors++; $display("FAIL stall_timeout got %0d enabled edges without done, need done after 8", en_cnt);
    end
    shift_en = 1'b0;
    step();
  endtask

  // Scenario 4: a 3C load offered mid-word must be ignored and not queued.
  task automatic test_ignore_load();
    logic [7:0] w;
    w = 8'h81;
    datain = w; load_valid = 1'b1; shift_en = 1'b1; serial = 1'b0;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin load_valid = 1'b1; datain = 8'h3C; end
      if (i == 6) load_valid = 1'b0;
      checks++; if (sout0 !== w[7-i] || sout1 !== w[i]) begin errors++; $display("FAIL ignore_sout[%0d] got %b/%b need %b/%b", i, sout0, sout1, w[7-i], w[i]); end
      step();
    end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL ignore_done got %b need 1", done0); end
    step();
    checks++; if (busy0 !== 1'b0 || load_ready0 !== 1'b1) begin errors++; $display("FAIL ignore_no_queue got busy=%b ready=%b need 0/1", busy0, load_ready0); end
  endtask

  // Load accepted in the done cycle: C6 then 5A with no gap.
  task automatic test_back_to_back();
    logic [7:0] w;
    logic [7:0] v;
    w = 8'hC6; v = 8'h5A;
    datain = w; load_valid = 1'b1; shift_en = 1'b1; serial = 1'b0;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (sout0 !== w[7-i]) begin errors++; $display("FAIL b2b_first_sout[%0d] got %b need %b", i, sout0, w[7-i]); end
      step();
    end
    checks++; if (done0 !== 1'b1 || load_ready0 !== 1'b1) begin errors++; $display("FAIL b2b_done_ready got done=%b ready=%b need 1/1", done0, load_ready0); end
    datain = v; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    checks++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin errors++; $display("FAIL b2b_reload got busy=%b done=%b need 1/0", busy0, done0); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (sout0 !== v[7-i] || sout1 !== v[i]) begin errors++; $display("FAIL b2b_second_sout[%0d] got %b/%b need %b/%b", i, sout0, sout1, v[7-i], v[i]); end
      step();
    end
    checks++; if (done0 !== 1'b1 || done1 !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b/%b need 1/1", done0, done1); end
    step();
  endtask

  // Scenario 5: async reset after 3 shifts abandons the word.
  task automatic test_reset_mid();
    datain = 8'hA5; load_valid = 1'b1; shift_en = 1'b1; serial = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (sout0 !== 1'b0 || sout1 !== 1'b0) begin errors++; $display("FAIL rstmid_sout got %b/%b need 0/0", sout0, sout1); end
    checks++; if (done0 !== 1'b0 || load_ready0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_state got done=%b ready=%b busy=%b need 0/1/0", done0, load_ready0, busy0); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (done0 !== 1'b0 || busy0 !== 1'b0 || sout0 !== 1'b0) begin errors++; $display("FAIL rstmid_after[%0d] got done=%b busy=%b sout=%b need 0/0/0", i, done0, busy0, sout0); end
    end
  endtask

  task automatic test_width1();
    lv2 = 1'b1; d2 = 1'b1; se2 = 1'b1; ser2 = 1'b0;
    step();
    lv2 = 1'b0;
    checks++; if (so2 !== 1'b1 || busy2 !== 1'b1 || done2 !== 1'b0) begin errors++; $display("FAIL w1_load got sout=%b busy=%b done=%b need 1/1/0", so2, busy2, done2); end
    step();
    checks++; if (done2 !== 1'b1 || busy2 !== 1'b0 || so2 !== 1'b0) begin errors++; $display("FAIL w1_done got done=%b busy=%b sout=%b need 1/0/0", done2, busy2, so2); end
    step();
    checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL w1_done_width got %b need 0", done2); end
    lv2 = 1'b1; d2 = 1'b0; se2 = 1'b0; ser2 = 1'b1;
    step();
    lv2 = 1'b0;
    step();
    checks++; if (busy2 !== 1'b1 || done2 !== 1'b0 || so2 !== 1'b0) begin errors++; $display("FAIL w1_stall got busy=%b done=%b sout=%b need 1/0/0", busy2, done2, so2); end
    se2 = 1'b1;
    step();
    checks++; if (done2 !== 1'b1 || so2 !== 1'b1) begin errors++; $display("FAIL w1_stall_done got done=%b sout=%b need 1/1", done2, so2); end
    se2 = 1'b0;
    step();
  endtask

`ifdef SHIFTREG_CAPTURE_EN
  // Scenario 6: load 00, receive 1,1,0,0,1,0,1,0.
  task automatic test_capture();
    logic [7:0] s;
    s = 8'b1100_1010;
    datain = 8'h00; load_valid = 1'b1; shift_en = 1'b1; serial = 1'b0;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (pv0 !== 1'b0) begin errors++; $display("FAIL cap_valid_early[%0d] got %b need 0", i, pv0); end
      serial = s[7-i];
      step();
    end
    checks++; if (pv0 !== 1'b1 || done0 !== 1'b1 || pv1 !== 1'b1) begin errors++; $display("FAIL cap_valid got pv=%b done=%b pv1=%b need 1/1/1", pv0, done0, pv1); end
    checks++; if (pdata0 !== 8'hCA) begin errors++; $display("FAIL cap_pdata_msb got %h need ca", pdata0); end
    checks++; if (pdata1 !== 8'h53) begin errors++; $display("FAIL cap_pdata_lsb got %h need 53", pdata1); end
    serial = 1'b0;
    step();
    checks++; if (pv0 !== 1'b0 || pdata0 !== 8'hCA) begin errors++; $display("FAIL cap_hold got pv=%b pdata=%h need 0/ca", pv0, pdata0); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    load_valid = 1'b0; datain = 8'h00; shift_en = 1'b0; serial = 1'b0;
    lv2 = 1'b0; d2 = 1'b0; se2 = 1'b0; ser2 = 1'b0;
    #1;
    test_reset();
    test_shift_order();
    test_idle_hold();
    test_stall();
    test_ignore_load();
    test_back_to_back();
    test_reset_mid();
    test_width1();
`ifdef SHIFTREG_CAPTURE_EN
    test_capture();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
